// File: rtl/mem_store_unit_pkg.sv
// Shared definitions for the store unit: the size encodings (the low two bits
// of the store funct3), the FSM state encodings and the bus width.
package mem_store_unit_pkg;

  localparam int BUS_WIDTH = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_store_unit_if.sv
// Store command and memory write bus. The store unit uses the master side;
// the control FSM / memory model uses the slave side.
interface mem_store_unit_if;
  import mem_store_unit_pkg::*;

  logic                 store_start;
  logic [BUS_WIDTH-1:0] store_addr;
  logic [BUS_WIDTH-1:0] store_data;
  logic [1:0]           store_size;
  logic                 mem_ack;
  logic                 mem_req;
  logic                 mem_we;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0] mem_wdata;
  logic [3:0]           mem_be;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    input  store_start, store_addr, store_data, store_size, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, done, err
  );

  modport slave (
    output store_start, store_addr, store_data, store_size, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, done, err
  );

endinterface

// File: rtl/mem_store_unit_lane_align.sv
// store_lane_align: places the store value in its byte lanes and produces the
// byte enables, plus flags for a misaligned halfword/word and an illegal size.
module store_lane_align
  import mem_store_unit_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned,
  output logic        illegal
);

  // Replicate the low bytes across the word and shift the enables into place.
  always_comb begin
    wdata      = data;
    be         = 4'b1111;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (size)
      SIZE_B: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr;
      end
      SIZE_H: begin
        wdata      = {2{data[15:0]}};
        be         = 4'b0011 << {addr[1], 1'b0};
        misaligned = addr[0];
      end
      SIZE_W: begin
        misaligned = |addr;
      end
      default: begin
        be      = 4'b0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_store_unit.sv
// mem_store_unit: drives one store to memory as a req/ack write transaction and
// reports done/err to the control FSM.
// Build option: define MEM_STORE_MISALIGN_TRAP_EN to turn misaligned SH/SW into
// an error instead of silently dropping the low address bits.
module mem_store_unit #(
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_store_unit_if.master  bus
);
  import mem_store_unit_pkg::*;

  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e               state;
  logic [CW-1:0]        cnt;
  logic                 req_q, done_q, err_q, busy_q;
  logic [BUS_WIDTH-1:0] addr_q, wdata_q;
  logic [3:0]           be_q;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_mis, al_ill;
  logic        trap;

  store_lane_align u_align (
    .addr       (bus.store_addr[1:0]),
    .size       (bus.store_size),
    .data       (bus.store_data),
    .wdata      (al_wdata),
    .be         (al_be),
    .misaligned (al_mis),
    .illegal    (al_ill)
  );

`ifdef MEM_STORE_MISALIGN_TRAP_EN
  assign trap = al_ill | al_mis;
`else
  assign trap = al_ill;
`endif

  // Control FSM; every output is a flop so memory sees glitch-free signals.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.store_start) begin
            addr_q  <= {bus.store_addr[BUS_WIDTH-1:2], 2'b00};
            wdata_q <= al_wdata;
            be_q    <= al_be;
            cnt     <= '0;
            busy_q  <= 1'b1;
            if (trap) begin
              state <= ERR;
              err_q <= 1'b1;
            end else begin
              state <= REQ;
              req_q <= 1'b1;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // Ack takes priority over a coincident timeout.
          if (bus.mem_ack) begin
            state  <= DONE;
            req_q  <= 1'b0;
            done_q <= 1'b1;
          end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
            state <= ERR;
            req_q <= 1'b0;
            err_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: directed stores push their expected outcome into a
// queue; a monitor pops and compares whenever done or err pulses.
module tb_mem_store_unit;
  import mem_store_unit_pkg::*;

  typedef struct {
    string       name;
    logic        is_err;
    int          req_cycles;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  mem_store_unit_if bus();

  mem_store_unit #(.BUS_WIDTH(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: track the request phase, then score each completion pulse.
  int          req_cnt = 0;
  logic        prev_pulse = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      req_cnt    = 0;
      prev_pulse = 1'b0;
    end else begin
      if (prev_pulse) chk("busy_after_pulse", {31'd0, bus.busy}, 32'd0);
      prev_pulse = bus.done | bus.err;
      if (bus.done && bus.err) chk("done_err_overlap", 32'd1, 32'd0);
      if (bus.mem_req) begin
        chk("we_eq_req", {31'd0, bus.mem_we}, 32'd1);
        if (req_cnt == 0) begin
          cap_addr  = bus.mem_addr;
          cap_wdata = bus.mem_wdata;
          cap_be    = bus.mem_be;
        end else begin
          chk("stable_addr",  bus.mem_addr,  cap_addr);
          chk("stable_wdata", bus.mem_wdata, cap_wdata);
          chk("stable_be",    {28'd0, bus.mem_be}, {28'd0, cap_be});
        end
        req_cnt++;
      end
      if (bus.done || bus.err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {31'd0, bus.err}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_kind"}, {31'd0, bus.err}, {31'd0, e.is_err});
          chk({e.name, "_req_cycles"}, req_cnt, e.req_cycles);
          if (e.req_cycles > 0) begin
            chk({e.name, "_addr"},  cap_addr,  e.addr);
            chk({e.name, "_wdata"}, cap_wdata, e.wdata);
            chk({e.name, "_be"},    {28'd0, cap_be}, {28'd0, e.be});
          end
        end
        req_cnt = 0;
      end
    end
  end

  task automatic expect_op(input string name, input logic is_err, input int req_cycles,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    e.name = name; e.is_err = is_err; e.req_cycles = req_cycles;
    e.addr = addr; e.wdata = wdata; e.be = be;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk({name, "_idle_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
  endtask

  // ack_after < 0: never ack; otherwise ack after that many waiting REQ cycles.
  task automatic do_store(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input int ack_after);
    @(negedge clk);
    bus.store_start = 1'b1;
    bus.store_addr  = addr;
    bus.store_data  = data;
    bus.store_size  = size;
    @(negedge clk);
    bus.store_start = 1'b0;
    if (ack_after >= 0) begin
      repeat (ack_after) @(negedge clk);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
    end
    wait_idle(name);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_req"},   {31'd0, bus.mem_req}, 32'd0);
    chk({name, "_we"},    {31'd0, bus.mem_we},  32'd0);
    chk({name, "_addr"},  bus.mem_addr,  32'd0);
    chk({name, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({name, "_be"},    {28'd0, bus.mem_be}, 32'd0);
    chk({name, "_busy"},  {31'd0, bus.busy}, 32'd0);
    chk({name, "_done"},  {31'd0, bus.done}, 32'd0);
    chk({name, "_err"},   {31'd0, bus.err},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.store_start = 1'b0;
    bus.store_addr  = '0;
    bus.store_data  = '0;
    bus.store_size  = SIZE_W;
    bus.mem_ack     = 1'b0;

    // Outputs during reset.
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // SB, ack in the first REQ cycle.
    expect_op("sb", 1'b0, 1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
    do_store("sb", 32'h0000_1003, 32'h0000_00A5, SIZE_B, 0);

    // SB lane 0, one wait state.
    expect_op("sb0", 1'b0, 2, 32'h0000_0000, 32'h5A5A_5A5A, 4'b0001);
    do_store("sb0", 32'h0000_0000, 32'hFFFF_FF5A, SIZE_B, 1);

    // SH upper half, three wait states.
    expect_op("sh", 1'b0, 4, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    do_store("sh", 32'h0000_2002, 32'h1234_BEEF, SIZE_H, 3);

    // SW with no ack: times out after exactly TIMEOUT request cycles.
    expect_op("timeout", 1'b1, 4, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
    do_store("timeout", 32'h0000_3000, 32'hDEAD_BEEF, SIZE_W, -1);

    // Misaligned SW.
`ifdef MEM_STORE_MISALIGN_TRAP_EN
    expect_op("sw_mis", 1'b1, 0, 32'h0, 32'h0, 4'b0000);
`else
    expect_op("sw_mis", 1'b0, 1, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111);
`endif
    do_store("sw_mis", 32'h0000_4001, 32'hCAFE_F00D, SIZE_W, 0);

    // Illegal size: error with no request.
    expect_op("illegal", 1'b1, 0, 32'h0, 32'h0, 4'b0000);
    do_store("illegal", 32'h0000_7000, 32'h1111_2222, 2'b11, -1);

    // store_start while in REQ must not disturb the transaction.
    expect_op("start_in_req", 1'b0, 3, 32'h0000_5000, 32'h1122_3344, 4'b1111);
    @(negedge clk);
    bus.store_start = 1'b1; bus.store_addr = 32'h0000_5000;
    bus.store_data = 32'h1122_3344; bus.store_size = SIZE_W;
    @(negedge clk);
    bus.store_addr = 32'h0000_5557; bus.store_data = 32'h0000_0099; bus.store_size = SIZE_B;
    @(negedge clk);
    bus.store_start = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    wait_idle("start_in_req");

    // Ack while idle does nothing.
    bus.mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_busy", {31'd0, bus.busy}, 32'd0);
      chk("idle_ack_req",  {31'd0, bus.mem_req}, 32'd0);
    end
    bus.mem_ack = 1'b0;

    // Asynchronous reset in the middle of a request.
    @(negedge clk);
    bus.store_start = 1'b1; bus.store_addr = 32'h0000_6000;
    bus.store_data = 32'h7777_8888; bus.store_size = SIZE_W;
    @(negedge clk);
    bus.store_start = 1'b0;
    chk("pre_reset_req", {31'd0, bus.mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_store_unit.md
Name: mem_store_unit

Overview:
- Memory write-side counterpart of the memory data register: the data register captures load data coming back from memory; this block drives store data out to memory.
- Takes a store command from the multi-cycle control FSM: byte address, rs2 value and store size (SB/SH/SW).
- Aligns the data into byte lanes, generates byte enables and holds a req/ack write transaction until memory accepts it.
- Reports completion or error to the control FSM.

Parameters:
- BUS_WIDTH, 32, data/address bus width; only 32 is supported.
- TIMEOUT, 16, maximum cycles in REQ without mem_ack before ERR; 0 disables the timeout.

Ports:
- clk  input  1  clock; all flops update on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- store_start  input  1  one-cycle command strobe from the control FSM.
- store_addr  input  32  byte address (ALU result).
- store_data  input  32  unaligned store value (rs2).
- store_size  input  2  00=SB, 01=SH, 10=SW, 11=illegal.
- mem_ack  input  1  memory accepted the write.
- mem_req  output  1  write request valid.
- mem_we  output  1  write enable; equal to mem_req.
- mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  output  32  lane-aligned write data.
- mem_be  output  4  byte enables.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse on successful write.
- err  output  1  one-cycle pulse on illegal size, misalignment or timeout.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including mem_addr, mem_wdata and mem_be; timeout counter 0.
  - Reset mid-REQ drops mem_req immediately, without waiting for a clock edge.
- States:
  - IDLE: mem_req=0, busy=0.
    - store_start=1 registers the aligned address, data and byte enables.
    - Next state is REQ, or ERR if the request is illegal.
  - REQ: mem_req=mem_we=1; mem_addr, mem_wdata and mem_be are held stable.
    - Counter increments each cycle.
    - mem_ack=1 at a rising edge -> DONE.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> ERR.
  - DONE: done=1 for exactly one cycle, mem_req=0 -> IDLE.
  - ERR: err=1 for exactly one cycle, mem_req=0 -> IDLE.
- Latency: a store_start sampled at edge N gives mem_req high from N+1. If mem_ack is high in that first REQ cycle, done is high in the cycle after.
- Lane alignment, with a=store_addr[1:0]:
  - SB: wdata={4{d[7:0]}}, be=4'b0001<<a.
  - SH: wdata={2{d[15:0]}}, be=4'b0011<<(2*a[1]).
  - SW: wdata=d, be=4'b1111.
- store_size=11 -> ERR; no memory access is made.
- store_start while busy is ignored; no queueing.
- mem_ack outside REQ is ignored.
- mem_ack coincident with the timeout edge: the ack wins and the block goes to DONE.
- done and err are never high in the same cycle.
- The counter clears on entry to REQ.

Optional Feature:
- Macro: MEM_STORE_MISALIGN_TRAP_EN.
- Defined: SH with a[0]=1, or SW with a!=0, goes IDLE -> ERR; mem_req is never asserted.
- Undefined: misaligned low bits are silently ignored:
  - SH uses a[1] only.
  - SW uses be=4'b1111 at the word address.
  - The access proceeds normally.

Decomposition:
- Shared package/header holds:
  - Store size encodings SIZE_B/SIZE_H/SIZE_W (matching funct3[1:0]).
  - State encodings IDLE/REQ/DONE/ERR.
  - BUS_WIDTH.
- Sub-module: store_lane_align, purely combinational.
  - Inputs: addr[1:0], size, data.
  - Outputs: wdata, be, misaligned, illegal.
  - The FSM registers its outputs on store_start.

Test Plan:
- Reset: rst=0 mid-REQ -> mem_req=0 immediately, busy=0; after release, state is IDLE with all outputs 0.
- SB: addr=0x1003, data=0x000000A5, ack on the 1st REQ cycle -> mem_addr=0x1000, wdata=0xA5A5A5A5, be=1000; done pulses once.
- SH with wait states: addr=0x2002, data=0x1234BEEF, ack after 3 cycles -> wdata=0xBEEFBEEF, be=1100; mem_req is high for 4 cycles with outputs stable; done pulses once.
- Timeout: TIMEOUT=4, SW to 0x3000, no ack -> mem_req high exactly 4 cycles, then err pulse, busy low next cycle.
- Misaligned SW to 0x4001:
  - MEM_STORE_MISALIGN_TRAP_EN defined -> err pulse, mem_req never high.
  - Undefined -> be=1111 at 0x4000, done pulse.
- Illegal size=11 -> err, no request; store_start during REQ is ignored, and ack arriving in IDLE has no effect.
